// File: rtl/i2c_target.sv
// I2C target with a 32-entry register pointer: a write transfer loads the
// pointer and then writes data bytes with auto-increment; a read transfer
// returns reg_rdata at the current pointer, auto-incrementing on each ACK.
// Optional SCL/SDA glitch filter is compiled in with I2C_TARGET_GLITCH_FILTER_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | not addressed, SDA released, bits ignored until START
// ADDR      | shifting in 7-bit address + R/W
// ADDR_ACK  | address matched, driving ACK for the 9th clock
// PTR       | shifting in the register pointer byte
// PTR_ACK   | driving ACK for the pointer byte
// WDATA     | shifting in a write data byte
// WDATA_ACK | driving ACK for the data byte, pointer increments after it
// RDATA     | shifting out the byte loaded from reg_rdata
// RDATA_ACK | SDA released, sampling controller ACK/NACK
module i2c_target #(
   parameter logic [6:0] DEV_ADDR = 7'h3B,
   parameter int         FILT_LEN = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i2c_scl_i,
   input  logic       i2c_sda_i,
   output logic       i2c_sda_t,
   output logic [4:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_write,
   input  logic [7:0] reg_rdata,
   output logic       busy,
   output logic       error
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
   } state_t;

   logic [1:0] scl_sync_q, sda_sync_q;
   logic       scl_f, sda_f;
   logic       scl_p_q, sda_p_q;

   // two-flop synchronizers, idle bus level out of reset
   always_ff @(posedge clk) begin
      if (reset) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
      end else begin
         scl_sync_q <= {scl_sync_q[0], i2c_scl_i};
         sda_sync_q <= {sda_sync_q[0], i2c_sda_i};
      end
   end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
   localparam int CW = $clog2(FILT_LEN + 1);
   logic          scl_f_q, sda_f_q;
   logic [CW-1:0] scl_cnt_q, sda_cnt_q;

   // a line change is accepted only after FILT_LEN consecutive disagreeing samples
   always_ff @(posedge clk) begin
      if (reset) begin
         scl_f_q   <= 1'b1;
         sda_f_q   <= 1'b1;
         scl_cnt_q <= '0;
         sda_cnt_q <= '0;
      end else begin
         if (scl_sync_q[1] != scl_f_q) begin
            if (scl_cnt_q == CW'(FILT_LEN - 1)) begin
               scl_f_q   <= scl_sync_q[1];
               scl_cnt_q <= '0;
            end else begin
               scl_cnt_q <= scl_cnt_q + 1'b1;
            end
         end else begin
            scl_cnt_q <= '0;
         end
         if (sda_sync_q[1] != sda_f_q) begin
            if (sda_cnt_q == CW'(FILT_LEN - 1)) begin
               sda_f_q   <= sda_sync_q[1];
               sda_cnt_q <= '0;
            end else begin
               sda_cnt_q <= sda_cnt_q + 1'b1;
            end
         end else begin
            sda_cnt_q <= '0;
         end
      end
   end

   assign scl_f = scl_f_q;
   assign sda_f = sda_f_q;
`else
   assign scl_f = scl_sync_q[1];
   assign sda_f = sda_sync_q[1];
`endif

   // previous-sample flops for edge and START/STOP detection
   always_ff @(posedge clk) begin
      if (reset) begin
         scl_p_q <= 1'b1;
         sda_p_q <= 1'b1;
      end else begin
         scl_p_q <= scl_f;
         sda_p_q <= sda_f;
      end
   end

   logic scl_rise, scl_fall, start_det, stop_det;
   assign scl_rise  = scl_f & ~scl_p_q;
   assign scl_fall  = ~scl_f & scl_p_q;
   assign start_det = scl_f & scl_p_q & sda_p_q & ~sda_f;
   assign stop_det  = scl_f & scl_p_q & ~sda_p_q & sda_f;

   state_t     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] rx_byte;
   logic [4:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic       sda_t_q, sda_t_d;
   logic       write_q, write_d;
   logic       busy_q, busy_d;
   logic       error_q, error_d;
   logic       rw_q, rw_d;
   logic       wrote_q, wrote_d;
   logic       load_q, load_d;

   assign rx_byte = {shift_q[6:0], sda_f};

   // next-state and output logic; bus conditions win over data-bit edges
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      sda_t_d   = sda_t_q;
      write_d   = 1'b0;
      error_d   = error_q;
      rw_d      = rw_q;
      wrote_d   = wrote_q;
      load_d    = 1'b0;
      // load one clk after entering RDATA so an incremented pointer is seen
      if (load_q) shift_d = reg_rdata;
      if (start_det) begin
         state_d   = ADDR;
         bit_cnt_d = '0;
         sda_t_d   = 1'b1;
         wrote_d   = 1'b0;
      end else if (stop_det) begin
         if (state_q == WDATA && !wrote_q) error_d = 1'b1;
         state_d = IDLE;
         sda_t_d = 1'b1;
      end else if (scl_rise) begin
         case (state_q)
            ADDR, PTR, WDATA: begin
               shift_d   = rx_byte;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  if (state_q == ADDR) begin
                     if (rx_byte[7:1] == DEV_ADDR) begin
                        state_d = ADDR_ACK;
                        rw_d    = rx_byte[0];
                     end else begin
                        state_d = IDLE;
                     end
                  end else if (state_q == PTR) begin
                     addr_d  = rx_byte[4:0];
                     state_d = PTR_ACK;
                  end else begin
                     wdata_d = rx_byte;
                     write_d = 1'b1;
                     wrote_d = 1'b1;
                     state_d = WDATA_ACK;
                  end
               end
            end
            ADDR_ACK: begin
               state_d = rw_q ? RDATA : PTR;
               load_d  = rw_q;
            end
            PTR_ACK:   state_d = WDATA;
            WDATA_ACK: begin
               addr_d  = addr_q + 5'd1;
               state_d = WDATA;
            end
            RDATA: begin
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = RDATA_ACK;
            end
            RDATA_ACK: begin
               if (!sda_f) begin
                  addr_d  = addr_q + 5'd1;
                  state_d = RDATA;
                  load_d  = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
            default: ;
         endcase
      end else if (scl_fall) begin
         case (state_q)
            ADDR_ACK, PTR_ACK, WDATA_ACK: sda_t_d = 1'b0;
            RDATA: begin
               sda_t_d = shift_q[7];
               shift_d = {shift_q[6:0], 1'b1};
            end
            default: sda_t_d = 1'b1;
         endcase
      end
      busy_d = (state_d != IDLE) && (state_d != ADDR);
   end

   // protocol state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         sda_t_q   <= 1'b1;
         write_q   <= 1'b0;
         busy_q    <= 1'b0;
         error_q   <= 1'b0;
         rw_q      <= 1'b0;
         wrote_q   <= 1'b0;
         load_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         sda_t_q   <= sda_t_d;
         write_q   <= write_d;
         busy_q    <= busy_d;
         error_q   <= error_d;
         rw_q      <= rw_d;
         wrote_q   <= wrote_d;
         load_q    <= load_d;
      end
   end

   assign i2c_sda_t = sda_t_q;
   assign reg_addr  = addr_q;
   assign reg_wdata = wdata_q;
   assign reg_write = write_q;
   assign busy      = busy_q;
   assign error     = error_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed + randomized bench for i2c_target: a bit-banged I2C controller,
// a 32-byte register file behind reg_addr/reg_rdata, and a reference memory
// image built from the bytes the controller sends.
module tb_i2c_target;

   logic       clk = 1'b0;
   logic       reset;
   logic       scl_drv, sda_drv;
   logic       i2c_scl_i, i2c_sda_i, i2c_sda_t;
   logic [4:0] reg_addr;
   logic [7:0] reg_wdata, reg_rdata;
   logic       reg_write, busy, error;

   logic [7:0]  mem [32];
   logic [7:0]  exp_mem [32];
   logic [7:0]  tx [8];
   logic [12:0] wr_log [$];
   int          low_cnt = 0;
   int          dbl_cnt = 0;
   logic        prev_write = 1'b0;
   int          total = 0;
   int          bad = 0;

   localparam int HALF = 16;

   i2c_target dut (
      .clk       (clk),
      .reset     (reset),
      .i2c_scl_i (i2c_scl_i),
      .i2c_sda_i (i2c_sda_i),
      .i2c_sda_t (i2c_sda_t),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_write (reg_write),
      .reg_rdata (reg_rdata),
      .busy      (busy),
      .error     (error)
   );

   always #5 clk = ~clk;

   assign i2c_scl_i = scl_drv;
   assign i2c_sda_i = sda_drv & i2c_sda_t;
   assign reg_rdata = mem[reg_addr];

   always @(negedge clk) begin
      if (reg_write) wr_log.push_back({reg_addr, reg_wdata});
      if (reg_write && prev_write) dbl_cnt = dbl_cnt + 1;
      prev_write = reg_write;
      if (!i2c_sda_t) low_cnt = low_cnt + 1;
   end

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic i2c_start();
      scl_drv = 1'b1; sda_drv = 1'b1; clks(HALF);
      sda_drv = 1'b0; clks(HALF);
      scl_drv = 1'b0;
   endtask

   task automatic i2c_rstart();
      clks(8); sda_drv = 1'b1; clks(8);
      scl_drv = 1'b1; clks(HALF);
      sda_drv = 1'b0; clks(HALF);
      scl_drv = 1'b0;
   endtask

   task automatic i2c_stop();
      clks(8); sda_drv = 1'b0; clks(8);
      scl_drv = 1'b1; clks(HALF);
      sda_drv = 1'b1; clks(HALF);
   endtask

   task automatic bit_io(input logic b, output logic r);
      clks(8); sda_drv = b; clks(8);
      scl_drv = 1'b1; clks(8);
      r = i2c_sda_i; clks(8);
      scl_drv = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bit_io(d[i], r);
      bit_io(1'b1, ack);
   endtask

   task automatic recv_byte(input logic nack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) bit_io(1'b1, d[i]);
      bit_io(nack, r);
   endtask

   task automatic wr_txn(input logic [7:0] pb, input int n);
      logic a;
      int base;
      logic [12:0] got;
      logic [4:0] p;
      base = wr_log.size();
      p = pb[4:0];
      i2c_start();
      send_byte(8'h76, a);  chk("w_addr_ack", a, 0);
      chk("w_busy", busy, 1);
      send_byte(pb, a);     chk("w_ptr_ack", a, 0);
      for (int i = 0; i < n; i++) begin
         send_byte(tx[i], a); chk("w_data_ack", a, 0);
      end
      i2c_stop();
      chk("w_busy_end", busy, 0);
      chk("w_count", wr_log.size(), base + n);
      for (int i = 0; i < n; i++) begin
         got = (base + i < wr_log.size()) ? wr_log[base + i] : 'x;
         chk("w_entry", got, {5'(p + i), tx[i]});
         exp_mem[5'(p + i)] = tx[i];
      end
      for (int k = base; k < wr_log.size(); k++) mem[wr_log[k][12:8]] = wr_log[k][7:0];
      chk("w_final_ptr", reg_addr, 5'(p + n));
   endtask

   task automatic rd_txn(input logic [7:0] pb, input int n);
      logic a;
      logic [7:0] d;
      logic [4:0] p;
      p = pb[4:0];
      i2c_start();
      send_byte(8'h76, a); chk("r_addr_ack", a, 0);
      send_byte(pb, a);    chk("r_ptr_ack", a, 0);
      i2c_rstart();
      send_byte(8'h77, a); chk("r_addr2_ack", a, 0);
      chk("r_busy", busy, 1);
      for (int i = 0; i < n; i++) begin
         recv_byte(i == n - 1, d);
         chk("r_data", d, exp_mem[5'(p + i)]);
      end
      chk("r_idle_busy", busy, 0);
      chk("r_idle_sda", i2c_sda_t, 1);
      i2c_stop();
      chk("r_final_ptr", reg_addr, 5'(p + n - 1));
   endtask

   initial begin
      logic a;
      logic r;
      int base;
      int lows;
      logic exp_glitch_busy;
      reset = 1'b1; scl_drv = 1'b1; sda_drv = 1'b1;
      for (int i = 0; i < 32; i++) begin
         mem[i] = 8'($urandom);
         exp_mem[i] = mem[i];
      end
      clks(3);
      chk("rst_sda_t", i2c_sda_t, 1);
      chk("rst_addr", reg_addr, 0);
      chk("rst_wdata", reg_wdata, 0);
      chk("rst_write", reg_write, 0);
      chk("rst_busy", busy, 0);
      chk("rst_error", error, 0);
      reset = 1'b0;
      clks(4);

      // basic write: pointer 5, data A5
      tx[0] = 8'hA5;
      wr_txn(8'h05, 1);
      chk("w_no_error", error, 0);

      // read across the wrap 31 -> 0
      rd_txn(8'h1F, 2);

      // address mismatch
      base = wr_log.size(); lows = low_cnt;
      i2c_start();
      send_byte(8'h50, a); chk("mis_nack", a, 1);
      chk("mis_busy", busy, 0);
      send_byte(8'h12, a);
      i2c_stop();
      chk("mis_sda_never_low", low_cnt, lows);
      chk("mis_no_write", wr_log.size(), base);

      // randomized write then read-back
      for (int t = 0; t < 3; t++) begin
         logic [4:0] p;
         int n;
         p = 5'($urandom_range(0, 31));
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) tx[i] = 8'($urandom);
         wr_txn({3'($urandom), p}, n);
         rd_txn({3'($urandom), p}, n);
      end

      // STOP after 3 bits of a second data byte
      base = wr_log.size();
      i2c_start();
      send_byte(8'h76, a);
      send_byte(8'h08, a);
      send_byte(8'h3C, a);
      bit_io(1'b1, r); bit_io(1'b0, r); bit_io(1'b1, r);
      i2c_stop();
      chk("sib_count", wr_log.size(), base + 1);
      chk("sib_entry", wr_log[wr_log.size() - 1], {5'd8, 8'h3C});
      exp_mem[8] = 8'h3C; mem[8] = 8'h3C;
      chk("sib_busy", busy, 0);
      chk("sib_ptr", reg_addr, 9);
      chk("sib_no_error", error, 0);

      // glitch on SDA while SCL high during a data bit
      base = wr_log.size();
      i2c_start();
      send_byte(8'h76, a);
      send_byte(8'h02, a);
      send_byte(8'h11, a);
      clks(8); sda_drv = 1'b1; clks(8);
      scl_drv = 1'b1; clks(8);
      sda_drv = 1'b0; clks(2);
      sda_drv = 1'b1; clks(8);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
      exp_glitch_busy = 1'b1;
`else
      exp_glitch_busy = 1'b0;
`endif
      chk("glitch_busy", busy, exp_glitch_busy);
      scl_drv = 1'b0;
      i2c_stop();
      chk("glitch_writes", wr_log.size(), base + 1);
      exp_mem[2] = 8'h11; mem[2] = 8'h11;

      // reset during the 4th data bit
      base = wr_log.size();
      i2c_start();
      send_byte(8'h76, a);
      send_byte(8'h0A, a);
      bit_io(1'b0, r); bit_io(1'b1, r); bit_io(1'b0, r);
      clks(8); sda_drv = 1'b1; clks(8);
      scl_drv = 1'b1; clks(4);
      reset = 1'b1; clks(1);
      chk("rmid_sda_t", i2c_sda_t, 1);
      chk("rmid_busy", busy, 0);
      scl_drv = 1'b1; sda_drv = 1'b1; clks(4);
      reset = 1'b0; clks(4);
      chk("rmid_addr", reg_addr, 0);
      lows = low_cnt;
      scl_drv = 1'b0;
      for (int i = 0; i < 5; i++) bit_io(1'b0, r);
      i2c_stop();
      chk("rmid_ignored_sda", low_cnt, lows);
      chk("rmid_no_write", wr_log.size(), base);
      tx[0] = 8'h5A; tx[1] = 8'hC3;
      wr_txn(8'h0A, 2);
      rd_txn(8'h0A, 2);

      // pointer-only write followed by STOP sets sticky error
      i2c_start();
      send_byte(8'h76, a);
      send_byte(8'h03, a);
      i2c_stop();
      chk("err_set", error, 1);
      tx[0] = 8'h77;
      wr_txn(8'h04, 1);
      chk("err_sticky", error, 1);
      reset = 1'b1; clks(2); reset = 1'b0; clks(2);
      chk("err_cleared", error, 0);

      chk("write_one_clk", dbl_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
